vga_ctrl: RTL and testbench
===========================

VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_SYNC, 96, hsync pulse width in pixel clocks.
REQ-002 Parameter H_BP, 48, horizontal back porch.
REQ-003 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-004 Parameter H_FP, 16, horizontal front porch; H_TOTAL = sum of the four = 800.
REQ-005 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-006 Parameter V_BP, 33, vertical back porch.
REQ-007 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-008 Parameter V_FP, 10, vertical front porch; V_TOTAL = sum of the four = 525.
REQ-009 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-010 clk  input  1  pixel clock (25 MHz), all state on rising edge.
REQ-011 rst  input  1  synchronous active-high reset.
REQ-012 vga_data  input  24  pixel from consumer, {R[23:16],G[15:8],B[7:0]}, registered by consumer one clk after h_addr/v_addr.
REQ-013 h_addr  output  10  visible column 0..639, else 0.
REQ-014 v_addr  output  10  visible row 0..479, else 0.
REQ-015 hsync  output  1  horizontal sync, active low.
REQ-016 vsync  output  1  vertical sync, active low.
REQ-017 valid  output  1  high when vga_r/g/b carry a visible pixel.
REQ-018 vga_r, vga_g, vga_b  output  8 each  pixel colour to DAC.
REQ-019 frame_tick  output  1  one-clk pulse per frame, for consumer motion timing.

Function
REQ-020 h_cnt SHALL count 0..H_TOTAL-1 every clk, wrapping to 0; v_cnt SHALL increment only when h_cnt wraps, wrapping 0 after V_TOTAL-1.
REQ-021 Region decode from counters: hs = h_cnt < H_SYNC; vs = v_cnt < V_SYNC; h_act = H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE (144..783); v_act = V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE (35..514).
REQ-022 h_addr = h_cnt-144 and v_addr = v_cnt-35 (10-bit) when h_act & v_act, else both 0; combinational from counter registers, zero added latency.
REQ-023 Stage 1 SHALL register hs, vs, act = h_act & v_act of the current counter position.
REQ-024 Stage 2 SHALL register hsync = ~hs_s1, vsync = ~vs_s1, valid = act_s1, {vga_r,vga_g,vga_b} = act_s1 ? vga_data : 0.
REQ-025 Total latency: counter position P -> hsync/vsync/valid/RGB for P visible 2 clks later; all outputs mutually aligned.
REQ-026 frame_tick SHALL be registered, high for exactly the one clk in which (h_cnt,v_cnt) = (0,0), period H_TOTAL*V_TOTAL = 420000 clks.
REQ-027 Blanking: RGB SHALL be 0 whenever valid = 0 regardless of vga_data.
REQ-028 Counter widths 10 bits; no count outside 0..799 / 0..524 reachable.

Reset
REQ-029 With rst high at an edge: h_cnt = v_cnt = 0, stage-1 regs inactive (hs=vs=act=0), hsync = vsync = 1, valid = 0, RGB = 0, frame_tick = 0.
REQ-030 Reset mid-frame SHALL abort the frame; first clk after release counters are (0,0) and counting restarts, with frame_tick pulsing in that first cycle only if rst is already low.
REQ-031 rst dominates all other updates in the same cycle.

Verification
REQ-032 rst high 3 clks -> hsync=vsync=1, valid=0, RGB=0, h_addr=v_addr=0; after release, h_cnt reaches 799 after 800 clks and wraps.
REQ-033 Line timing -> hsync low exactly 96 of every 800 clks, vsync low exactly 1600 of every 420000 clks; both edges lag counter by 2 clks.
REQ-034 Address map -> (h,v)=(144,35) gives h_addr=0,v_addr=0; (783,514) gives 639,479; (784,35) and (144,515) give 0,0.
REQ-035 Consumer model registers vga_data = {8'hA5, h_addr[7:0], v_addr[7:0]} -> at every valid clk vga_r=A5, vga_g/vga_b match the address driven 2 clks earlier; 307200 valid clks per frame.
REQ-036 frame_tick -> single-clk pulses 420000 clks apart.
REQ-037 rst asserted at (400,200) for 1 clk -> outputs inactive next clk, counters (0,0) after release, next frame_tick 420000 clks after restart.

Source files
------------

// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running pixel/line counters, combinational
// pixel address for the consumer, and a two-stage output pipeline that
// keeps sync, valid and colour aligned with the consumer's one-clk data latency.
module vga_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] vga_data,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        valid,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_END = 10'(H_SYNC);
   localparam logic [9:0] VS_END = 10'(V_SYNC);
   localparam logic [9:0] HA_BEG = 10'(H_SYNC + H_BP);
   localparam logic [9:0] HA_END = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0] VA_BEG = 10'(V_SYNC + V_BP);
   localparam logic [9:0] VA_END = 10'(V_SYNC + V_BP + V_ACTIVE);

   logic [9:0]  r_h_cnt, r_v_cnt;
   logic [9:0]  w_h_nxt, w_v_nxt;
   logic        w_h_last, w_v_last;
   logic        w_hs, w_vs, w_h_act, w_v_act, w_act;
   logic        r_hs_s1, r_vs_s1, r_act_s1;
   logic        r_hsync, r_vsync, r_valid, r_frame_tick;
   logic [23:0] r_rgb;

   // Next counter position; line counter only moves on the pixel wrap.
   assign w_h_last = (r_h_cnt == H_LAST);
   assign w_v_last = (r_v_cnt == V_LAST);
   assign w_h_nxt  = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
   assign w_v_nxt  = !w_h_last ? r_v_cnt : (w_v_last ? 10'd0 : r_v_cnt + 10'd1);

   // Region decode of the current counter position.
   assign w_hs    = (r_h_cnt < HS_END);
   assign w_vs    = (r_v_cnt < VS_END);
   assign w_h_act = (r_h_cnt >= HA_BEG) && (r_h_cnt < HA_END);
   assign w_v_act = (r_v_cnt >= VA_BEG) && (r_v_cnt < VA_END);
   assign w_act   = w_h_act && w_v_act;

   // Address is zero-latency so the consumer can register its pixel in step
   // with stage 1.
   assign h_addr = w_act ? (r_h_cnt - HA_BEG) : 10'd0;
   assign v_addr = w_act ? (r_v_cnt - VA_BEG) : 10'd0;

   // Position counters; reset aborts the frame and restarts at (0,0).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
      end else begin
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
      end
   end

   // Frame tick is high exactly while the counters sit at (0,0) after a wrap,
   // so it is computed from the next position.
   always_ff @(posedge clk) begin
      if (rst) r_frame_tick <= 1'b0;
      else     r_frame_tick <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
   end

   // Stage 1: capture region flags while the consumer fetches the pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs_s1  <= 1'b0;
         r_vs_s1  <= 1'b0;
         r_act_s1 <= 1'b0;
      end else begin
         r_hs_s1  <= w_hs;
         r_vs_s1  <= w_vs;
         r_act_s1 <= w_act;
      end
   end

   // Stage 2: drive syncs (active low), valid and blanked colour together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_valid <= 1'b0;
         r_rgb   <= 24'd0;
      end else begin
         r_hsync <= ~r_hs_s1;
         r_vsync <= ~r_vs_s1;
         r_valid <= r_act_s1;
         r_rgb   <= r_act_s1 ? vga_data : 24'd0;
      end
   end

   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign valid      = r_valid;
   assign vga_r      = r_rgb[23:16];
   assign vga_g      = r_rgb[15:8];
   assign vga_b      = r_rgb[7:0];
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl on a shrunken raster (18 x 10) so whole frames fit in a
// short run. A position model queues the expected aligned outputs; a monitor
// pops and compares every clk. Directed checks cover reset, address corners,
// per-frame counts and frame_tick spacing.
module tb_vga_ctrl;

   localparam int HS = 4, HBP = 3, HA = 8, HFP = 3, HT = 18;
   localparam int VS = 2, VBP = 2, VA = 4, VFP = 2, VT = 10;
   localparam int FRAME = 180;
   localparam int HB = 7, VB = 4;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        vld;
      logic [23:0] rgb;
   } exp_t;

   localparam exp_t INACT = exp_t'{1'b1, 1'b1, 1'b0, 24'h0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] vga_data = 24'h0;
   logic [9:0]  h_addr, v_addr;
   logic        hsync, vsync, valid, frame_tick;
   logic [7:0]  vga_r, vga_g, vga_b;

   exp_t sb[$];
   int   checks = 0, errors = 0;
   int   hc = 0, vc = 0, cyc = 0;
   bit   tick_exp = 1'b0, mon_en = 1'b0;
   logic [9:0] ph = 10'd0, pv = 10'd0;

   vga_ctrl #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
   ) dut (
      .clk(clk), .rst(rst), .vga_data(vga_data),
      .h_addr(h_addr), .v_addr(v_addr),
      .hsync(hsync), .vsync(vsync), .valid(valid),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d pos %0d,%0d)", name, act, exp, cyc, hc, vc);
      end
   endtask

   function automatic exp_t model_out(input int h, input int v);
      exp_t e;
      bit act;
      act   = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
      e.hs  = !(h < HS);
      e.vs  = !(v < VS);
      e.vld = act;
      e.rgb = act ? {8'hA5, 8'(h - HB), 8'(v - VB)} : 24'h0;
      return e;
   endfunction

   // Position model: tracks the raster position of the current clk and
   // queues the output expected two clks later.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         hc = 0; vc = 0; tick_exp = 1'b0;
         sb.delete();
         sb.push_back(INACT);
         sb.push_back(INACT);
         sb.push_back(model_out(0, 0));
         mon_en = 1'b1;
      end else begin
         if (hc == HT - 1) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
         end else begin
            hc++;
         end
         tick_exp = (hc == 0) && (vc == 0);
         sb.push_back(model_out(hc, vc));
      end
   end

   // Consumer: presents the pixel for the address seen one clk earlier.
   initial begin
      forever begin
         @(negedge clk);
         vga_data = {8'hA5, ph[7:0], pv[7:0]};
         ph = h_addr;
         pv = v_addr;
      end
   end

   // Monitor: pops one expectation per clk and compares.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
               e = sb.pop_front();
               chk("hsync", hsync, e.hs);
               chk("vsync", vsync, e.vs);
               chk("valid", valid, e.vld);
               chk("rgb", {vga_r, vga_g, vga_b}, e.rgb);
               chk("frame_tick", frame_tick, tick_exp);
               if (hc >= HB && hc < HB + HA && vc >= VB && vc < VB + VA) begin
                  chk("h_addr", h_addr, hc - HB);
                  chk("v_addr", v_addr, vc - VB);
               end else begin
                  chk("h_addr_blank", h_addr, 0);
                  chk("v_addr_blank", v_addr, 0);
               end
            end
         end
      end
   end

   task automatic wait_pos(input int h, input int v);
      int n = 0;
      while (!(hc == h && vc == v) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++; errors++;
         $display("FAIL wait_pos actual=timeout required=%0d,%0d", h, v);
      end
   endtask

   task automatic wait_tick(output int at);
      int n = 0;
      @(negedge clk);
      while (!frame_tick && n < 400) begin
         @(negedge clk);
         n++;
      end
      at = cyc;
      if (n >= 400) begin
         checks++; errors++;
         $display("FAIL wait_tick actual=timeout required=pulse");
      end
   endtask

   int th[6] = '{6, 7, 15, 10, 14, 7};
   int tv[6] = '{4, 4, 4, 5, 7, 8};
   int eh[6] = '{0, 0, 0, 3, 7, 0};
   int ev[6] = '{0, 0, 0, 1, 3, 0};

   initial begin
      int n_hs, n_vs, n_vld, n_tick, t0, t1, r0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_valid", valid, 0);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("rst_h_addr", h_addr, 0);
      chk("rst_v_addr", v_addr, 0);
      chk("rst_tick", frame_tick, 0);
      rst = 1'b0;

      // Address corners
      for (int i = 0; i < 6; i++) begin
         wait_pos(th[i], tv[i]);
         chk($sformatf("amap_h_%0d_%0d", th[i], tv[i]), h_addr, eh[i]);
         chk($sformatf("amap_v_%0d_%0d", th[i], tv[i]), v_addr, ev[i]);
      end

      // One full frame of output statistics
      wait_pos(0, 0);
      n_hs = 0; n_vs = 0; n_vld = 0; n_tick = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (!hsync) n_hs++;
         if (!vsync) n_vs++;
         if (valid) n_vld++;
         if (frame_tick) n_tick++;
         @(negedge clk);
      end
      chk("frame_hsync_low", n_hs, 40);
      chk("frame_vsync_low", n_vs, 36);
      chk("frame_valid", n_vld, 32);
      chk("frame_ticks", n_tick, 1);

      // frame_tick spacing
      wait_tick(t0);
      wait_tick(t1);
      chk("tick_period", t1 - t0, FRAME);

      // Mid-frame reset inside the visible area
      wait_pos(9, 5);
      rst = 1'b1;
      @(negedge clk);
      r0 = cyc;
      chk("mrst_hsync", hsync, 1);
      chk("mrst_vsync", vsync, 1);
      chk("mrst_valid", valid, 0);
      chk("mrst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("mrst_h_addr", h_addr, 0);
      chk("mrst_v_addr", v_addr, 0);
      rst = 1'b0;
      wait_tick(t1);
      chk("restart_tick_delay", t1 - r0, FRAME);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
